// File: rtl/bitwise_logic_seq.sv
// bitwise_logic_seq: multi-cycle bitwise logic unit (AND / OR / XOR / NOR).
// Both WIDTH-bit operands and the opcode are latched on an accepted start.
// The result is then built SLICE bits per clock, LSB slice first.
// Handshake: busy is high while running; data_resultRDY pulses for one cycle
// when the result is complete; data_result holds until the next start.
// Optional feature: define BLU_ZERO_FLAG_EN to add the registered data_isZero
// output, which flags a zero final result.
module bitwise_logic_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [1:0]       ctrl_op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy
`ifdef BLU_ZERO_FLAG_EN
    ,
    output logic             data_isZero
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = $clog2(NSLICE + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    state_t             state_q;
    state_t             state_d;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic               rdy_q;

    logic               accept;
    logic               last_slice;
    logic               busy_d;
    logic               rdy_d;
    int                 slice_base;
    logic [SLICE-1:0]   a_slice;
    logic [SLICE-1:0]   b_slice;
    logic [SLICE-1:0]   slice_val;
    logic [WIDTH-1:0]   result_d;

    // A start is honoured only from IDLE or DONE; in RUN it is ignored.
    assign accept     = ctrl_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_slice = (cnt_q == LAST_CNT);

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples
        // pre-edge values, independent of the order in which processes run.
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on start; RUN -> DONE after the last slice; DONE -> RUN or IDLE.
    always_comb begin
        // NOTE: give every combinational output a default first, so that no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (ctrl_start) state_d = ST_RUN;
            ST_RUN:  if (last_slice) state_d = ST_DONE;
            ST_DONE: state_d = ctrl_start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode and the slice datapath: busy/RDY follow the next state, and the current slice is merged into the result.
    always_comb begin
        busy_d     = (state_d == ST_RUN);
        rdy_d      = (state_d == ST_DONE);
        slice_base = int'(cnt_q) * SLICE;
        a_slice    = a_q[slice_base +: SLICE];
        b_slice    = b_q[slice_base +: SLICE];
        unique case (op_q)
            OP_AND:  slice_val = a_slice & b_slice;
            OP_OR:   slice_val = a_slice | b_slice;
            OP_XOR:  slice_val = a_slice ^ b_slice;
            OP_NOR:  slice_val = ~(a_slice | b_slice);
            default: slice_val = '0;
        endcase
        result_d = result_q;
        result_d[slice_base +: SLICE] = slice_val;
    end

    // Operand latch, slice counter, result register and the registered handshake outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            op_q     <= OP_AND;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            busy_q <= busy_d;
            rdy_q  <= rdy_d;
            if (accept) begin
                op_q     <= op_t'(ctrl_op);
                a_q      <= data_operandA;
                b_q      <= data_operandB;
                cnt_q    <= '0;
                result_q <= '0;
            end else if (state_q == ST_RUN) begin
                cnt_q    <= cnt_q + CNT_W'(1);
                result_q <= result_d;
            end
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

`ifdef BLU_ZERO_FLAG_EN
    logic zero_q;

    // Zero flag: captured with the final slice (same edge RDY rises), cleared on each accepted start.
    always_ff @(posedge clock) begin
        if (!reset) begin
            zero_q <= 1'b0;
        end else if (accept) begin
            zero_q <= 1'b0;
        end else if ((state_q == ST_RUN) && last_slice) begin
            zero_q <= (result_d == '0);
        end
    end

    assign data_isZero = zero_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Testbench for bitwise_logic_seq.
// A transaction-level reference model predicts result, busy and RDY for the
// default instance (WIDTH=32, SLICE=8) on every cycle.
// Directed vectors with literal expectations pin that model.
// A SLICE=32 instance is covered with directed literal checks.
module tb_bitwise_logic_seq;

    localparam int W = 32;
    localparam int S = 8;
    localparam int N = W / S;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    logic          clock      = 1'b0;
    logic          reset      = 1'b0;
    logic          ctrl_start = 1'b0;
    logic          start32    = 1'b0;
    logic [1:0]    ctrl_op    = 2'b00;
    logic [W-1:0]  opa        = '0;
    logic [W-1:0]  opb        = '0;

    logic [W-1:0]  result;
    logic [W-1:0]  result32;
    logic          rdy;
    logic          rdy32;
    logic          busy;
    logic          busy32;
`ifdef BLU_ZERO_FLAG_EN
    logic          is_zero;
    logic          is_zero32;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    bitwise_logic_seq #(.WIDTH(W), .SLICE(S)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_op        (ctrl_op),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (result),
        .data_resultRDY (rdy),
        .busy           (busy)
`ifdef BLU_ZERO_FLAG_EN
        ,
        .data_isZero    (is_zero)
`endif
    );

    bitwise_logic_seq #(.WIDTH(W), .SLICE(W)) dut32 (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (start32),
        .ctrl_op        (ctrl_op),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (result32),
        .data_resultRDY (rdy32),
        .busy           (busy32)
`ifdef BLU_ZERO_FLAG_EN
        ,
        .data_isZero    (is_zero32)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic [W-1:0] low_mask(input int bits);
        logic [63:0] m;
        m = (64'd1 << bits) - 64'd1;
        return m[W-1:0];
    endfunction

    // Reference model: an operation is described by the number of edges since its start edge.
    bit            m_active = 1'b0;
    int            m_phase  = 0;
    logic [W-1:0]  m_full   = '0;
    logic [W-1:0]  m_res    = '0;
    logic          m_zero   = 1'b0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset) begin
            m_active <= 1'b0;
            m_phase  <= 0;
            m_res    <= '0;
            m_zero   <= 1'b0;
        end else if (ctrl_start && !(m_active && m_phase < N)) begin
            m_active <= 1'b1;
            m_phase  <= 0;
            m_res    <= '0;
            m_zero   <= 1'b0;
            m_full   <= ref_op(ctrl_op, opa, opb);
        end else if (m_active) begin
            m_phase <= m_phase + 1;
            if (m_phase + 1 > N) begin
                m_active <= 1'b0;
            end else begin
                m_res <= m_full & low_mask((m_phase + 1) * S);
                if (m_phase + 1 == N) m_zero <= (m_full == '0);
            end
        end
    end

    // Per-cycle comparison of the default instance against the model.
    always @(negedge clock) begin
        if (cyc > 0) begin
            check("model_result", result, m_res);
            check("model_busy", {31'b0, busy}, {31'b0, (m_active && m_phase < N)});
            check("model_rdy", {31'b0, rdy}, {31'b0, (m_active && m_phase == N)});
`ifdef BLU_ZERO_FLAG_EN
            check("model_zero", {31'b0, is_zero}, {31'b0, m_zero});
`endif
        end
    end

    // Present a request at a negedge; returns just after the start edge, with start dropped.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_op    = op;
        opa        = a;
        opb        = b;
        ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_rdy(output int at);
        int budget;
        budget = 40;
        while (rdy !== 1'b1 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (rdy !== 1'b1) check("rdy_timeout", {31'b0, rdy}, 32'd1);
        at = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t3, n;

        repeat (2) @(negedge clock);
        check("reset_result", result, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_rdy", {31'b0, rdy}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // AND with mid-run snapshots
        issue(OP_AND, 32'hFFFF0000, 32'h0F0F0F0F);
        check("and_busy_e0", {31'b0, busy}, 32'd1);
        check("and_result_e0", result, 32'h0);
        @(negedge clock);
        @(negedge clock);
        check("and_mid_e2", result, 32'h00000000);
        check("and_busy_e2", {31'b0, busy}, 32'd1);
        @(negedge clock);
        check("and_mid_e3", result, 32'h000F0000);
        check("and_busy_e3", {31'b0, busy}, 32'd1);
        @(negedge clock);
        check("and_rdy_e4", {31'b0, rdy}, 32'd1);
        check("and_busy_e4", {31'b0, busy}, 32'd0);
        check("and_result_e4", result, 32'h0F0F0000);
        @(negedge clock);
        check("and_rdy_e5", {31'b0, rdy}, 32'd0);
        check("and_hold_e5", result, 32'h0F0F0000);

        // OR / XOR / NOR back-to-back, each started in the DONE cycle
        issue(OP_OR, 32'hFFFF0000, 32'h0F0F0F0F);
        wait_rdy(t1);
        check("or_result", result, 32'hFFFF0F0F);
        issue(OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F);
        wait_rdy(t2);
        check("xor_result", result, 32'hF0F00F0F);
        issue(OP_NOR, 32'hFFFF0000, 32'h0F0F0F0F);
        wait_rdy(t3);
        check("nor_result", result, 32'h0000F0F0);
        check("b2b_spacing_1", t2 - t1, 32'd5);
        check("b2b_spacing_2", t3 - t2, 32'd5);
        @(negedge clock);

        // Start while busy is ignored
        issue(OP_AND, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clock);
        ctrl_op    = OP_XOR;
        opa        = 32'h12345678;
        opb        = 32'h0F0F0F0F;
        ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        wait_rdy(t1);
        check("ignore_result", result, 32'hFFFFFFFF);
        n = 0;
        repeat (10) begin
            @(negedge clock);
            if (rdy === 1'b1 || busy === 1'b1) n++;
        end
        check("ignore_no_second_op", n, 32'd0);
        check("ignore_hold", result, 32'hFFFFFFFF);

        // Reset mid-run aborts with no RDY
        issue(OP_AND, 32'hFFFF0000, 32'h0F0F0F0F);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("abort_result", result, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_rdy", {31'b0, rdy}, 32'd0);
        n = 0;
        repeat (8) begin
            @(negedge clock);
            if (rdy === 1'b1) n++;
        end
        check("abort_no_rdy", n, 32'd0);
        issue(OP_AND, 32'hFFFF0000, 32'h0F0F0F0F);
        wait_rdy(t1);
        check("after_abort_result", result, 32'h0F0F0000);
        @(negedge clock);

        // Reset wins over a simultaneous start
        reset      = 1'b0;
        ctrl_start = 1'b1;
        ctrl_op    = OP_OR;
        @(negedge clock);
        reset      = 1'b1;
        ctrl_start = 1'b0;
        check("prio_busy", {31'b0, busy}, 32'd0);
        check("prio_result", result, 32'h0);
        @(negedge clock);
        check("prio_busy_later", {31'b0, busy}, 32'd0);

        // SLICE == WIDTH instance
        ctrl_op = OP_AND;
        opa     = 32'h12345678;
        opb     = 32'hFF00FF00;
        start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        check("s32_busy_e0", {31'b0, busy32}, 32'd1);
        check("s32_rdy_e0", {31'b0, rdy32}, 32'd0);
        check("s32_result_e0", result32, 32'h0);
        @(negedge clock);
        check("s32_rdy_e1", {31'b0, rdy32}, 32'd1);
        check("s32_busy_e1", {31'b0, busy32}, 32'd0);
        check("s32_result_e1", result32, 32'h12005600);
        @(negedge clock);
        check("s32_rdy_e2", {31'b0, rdy32}, 32'd0);
        check("s32_hold_e2", result32, 32'h12005600);

`ifdef BLU_ZERO_FLAG_EN
        // Zero flag
        issue(OP_XOR, 32'hDEADBEEF, 32'hDEADBEEF);
        wait_rdy(t1);
        check("zero_result", result, 32'h0);
        check("zero_flag_set", {31'b0, is_zero}, 32'd1);
        issue(OP_OR, 32'h00000001, 32'h00000000);
        check("zero_flag_cleared", {31'b0, is_zero}, 32'd0);
        wait_rdy(t2);
        check("nonzero_result", result, 32'h00000001);
        check("zero_flag_nonzero", {31'b0, is_zero}, 32'd0);
`endif

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
